// File: rtl/register_file_if.sv
// Bus between writeback/operand-fetch and the register file.
// master drives write and read requests; slave returns read data and ready.
interface register_file_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic [1:0]        write;
  logic [DATA_W-1:0] wr1;
  logic [DATA_W-1:0] wr2;
  logic [ADDR_W-1:0] wa1;
  logic [ADDR_W-1:0] wa2;
  logic              re;
  logic [ADDR_W-1:0] ra1;
  logic [ADDR_W-1:0] ra2;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic              rd_valid;
  logic              ready;

  modport master (
    output write, wr1, wr2, wa1, wa2, re, ra1, ra2,
    input  rd1, rd2, rd_valid, ready
  );

  modport slave (
    input  write, wr1, wr2, wa1, wa2, re, ra1, ra2,
    output rd1, rd2, rd_valid, ready
  );
endinterface

// File: rtl/register_file.sv
// Two-write/two-read register file with registered, write-first reads.
// After reset an init sweep clears one entry per cycle before ready rises.
module register_file #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned DEPTH   = 32,
  parameter bit          R0_ZERO = 1'b0
) (
  input logic            clk,
  input logic            rst,
  register_file_if.slave bus
);

  typedef enum logic {
    INIT,
    RUN
  } state_e;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] rd1_q, rd1_d;
  logic [DATA_W-1:0] rd2_q, rd2_d;
  logic              rd_valid_q, rd_valid_d;
  logic              ready_q, ready_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              init_we;
  logic              we1;
  logic              we2;
  logic [DATA_W-1:0] mem_rd1;
  logic [DATA_W-1:0] mem_rd2;

  // Write enables; writes to entry 0 are dropped here when it is hardwired.
  always_comb begin
    init_we = !rst && (state_q == INIT);
    we1     = !rst && (state_q == RUN) && bus.write[0] &&
              !(R0_ZERO && (bus.wa1 == '0));
    we2     = !rst && (state_q == RUN) && bus.write[1] &&
              !(R0_ZERO && (bus.wa2 == '0));
  end

  // Port 2 is written last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (init_we) begin
      mem[cnt_q] <= '0;
    end
    if (we1) begin
      mem[bus.wa1] <= bus.wr1;
    end
    if (we2) begin
      mem[bus.wa2] <= bus.wr2;
    end
  end

  // Write-first bypass: port 2 checked last for priority, entry 0 forced last.
  always_comb begin
    mem_rd1 = mem[bus.ra1];
    if (we1 && (bus.wa1 == bus.ra1)) mem_rd1 = bus.wr1;
    if (we2 && (bus.wa2 == bus.ra1)) mem_rd1 = bus.wr2;
    if (R0_ZERO && (bus.ra1 == '0))  mem_rd1 = '0;

    mem_rd2 = mem[bus.ra2];
    if (we1 && (bus.wa1 == bus.ra2)) mem_rd2 = bus.wr1;
    if (we2 && (bus.wa2 == bus.ra2)) mem_rd2 = bus.wr2;
    if (R0_ZERO && (bus.ra2 == '0))  mem_rd2 = '0;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd1_d      = rd1_q;
    rd2_d      = rd2_q;
    rd_valid_d = 1'b0;
    ready_d    = ready_q;
    unique case (state_q)
      INIT: begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == LAST) begin
          state_d = RUN;
          ready_d = 1'b1;
        end
      end
      RUN: begin
        if (bus.re) begin
          rd1_d      = mem_rd1;
          rd2_d      = mem_rd2;
          rd_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = INIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= INIT;
      cnt_q      <= '0;
      rd1_q      <= '0;
      rd2_q      <= '0;
      rd_valid_q <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd1_q      <= rd1_d;
      rd2_q      <= rd2_d;
      rd_valid_q <= rd_valid_d;
      ready_q    <= ready_d;
    end
  end

  assign bus.rd1      = rd1_q;
  assign bus.rd2      = rd2_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.ready    = ready_q;

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: one instance with a normal entry 0, one with it
// hardwired to zero, both driven identically and checked against an array model.
module tb_register_file;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned DP = 32;

  logic clk;
  logic rst;

  register_file_if #(.DATA_W(DW), .ADDR_W(AW)) if0 ();
  register_file_if #(.DATA_W(DW), .ADDR_W(AW)) if1 ();

  register_file #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DP), .R0_ZERO(1'b0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (if0.slave)
  );

  register_file #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DP), .R0_ZERO(1'b1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // stimulus for the next edge
  logic          s_rst;
  logic [1:0]    s_write;
  logic [DW-1:0] s_wr1, s_wr2;
  logic [AW-1:0] s_wa1, s_wa2, s_ra1, s_ra2;
  logic          s_re;

  // reference model: k=0 normal, k=1 entry 0 hardwired to zero
  logic [DW-1:0] mm [2][DP];
  int            m_cyc;
  logic          m_ready;
  logic          m_rdv;
  logic [DW-1:0] m_rd1 [2];
  logic [DW-1:0] m_rd2 [2];

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic idle_inputs();
    s_rst = 1'b0; s_write = 2'b00; s_wr1 = '0; s_wr2 = '0;
    s_wa1 = '0; s_wa2 = '0; s_re = 1'b0; s_ra1 = '0; s_ra2 = '0;
  endtask

  task automatic model_edge();
    if (s_rst) begin
      m_cyc = 0; m_ready = 1'b0; m_rdv = 1'b0;
      for (int k = 0; k < 2; k++) begin m_rd1[k] = '0; m_rd2[k] = '0; end
    end else if (!m_ready) begin
      // contents only become observable once the whole sweep is done
      m_cyc++;
      m_rdv = 1'b0;
      if (m_cyc == DP) begin
        m_ready = 1'b1;
        for (int k = 0; k < 2; k++)
          for (int a = 0; a < DP; a++) mm[k][a] = '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (s_write[0] && !(k == 1 && s_wa1 == 0)) mm[k][s_wa1] = s_wr1;
        if (s_write[1] && !(k == 1 && s_wa2 == 0)) mm[k][s_wa2] = s_wr2;
        if (s_re) begin
          m_rd1[k] = mm[k][s_ra1];
          m_rd2[k] = mm[k][s_ra2];
        end
      end
      m_rdv = s_re;
    end
  endtask

  task automatic tick();
    rst = s_rst;
    if0.write = s_write; if0.wr1 = s_wr1; if0.wr2 = s_wr2; if0.wa1 = s_wa1;
    if0.wa2 = s_wa2; if0.re = s_re; if0.ra1 = s_ra1; if0.ra2 = s_ra2;
    if1.write = s_write; if1.wr1 = s_wr1; if1.wr2 = s_wr2; if1.wa1 = s_wa1;
    if1.wa2 = s_wa2; if1.re = s_re; if1.ra1 = s_ra1; if1.ra2 = s_ra2;
    @(posedge clk);
    model_edge();
    #1;
    check("ready0", DW'(if0.ready), DW'(m_ready));
    check("ready1", DW'(if1.ready), DW'(m_ready));
    check("rdv0", DW'(if0.rd_valid), DW'(m_rdv));
    check("rdv1", DW'(if1.rd_valid), DW'(m_rdv));
    check("rd1_0", if0.rd1, m_rd1[0]);
    check("rd2_0", if0.rd2, m_rd2[0]);
    check("rd1_1", if1.rd1, m_rd1[1]);
    check("rd2_1", if1.rd2, m_rd2[1]);
  endtask

  task automatic read_all_zero(input string tag);
    for (int a = 0; a < DP; a++) begin
      idle_inputs();
      s_re = 1'b1; s_ra1 = AW'(a); s_ra2 = AW'(DP - 1 - a);
      tick();
      check({tag, "_rd1"}, if0.rd1, '0);
      check({tag, "_rd2"}, if1.rd2, '0);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    idle_inputs();
    while (!if0.ready && n < 40) begin
      tick();
      n++;
    end
    check(tag, DW'(if0.ready), DW'(1));
  endtask

  initial begin
    idle_inputs();
    m_cyc = 0; m_ready = 1'b0; m_rdv = 1'b0;
    for (int k = 0; k < 2; k++) begin m_rd1[k] = '0; m_rd2[k] = '0; end

    // 1: reset, ready rises exactly DP cycles after release, contents zero
    s_rst = 1'b1; tick();
    check("rst_ready", DW'(if0.ready), '0);
    idle_inputs();
    for (int i = 0; i < DP - 1; i++) begin
      s_write = 2'b11; s_wa1 = AW'(i); s_wr1 = DW'($urandom); s_re = 1'b1;
      tick();
      check("init_ready_low", DW'(if0.ready), '0);
    end
    idle_inputs(); tick();
    check("ready_at_33", DW'(if0.ready), DW'(1));
    read_all_zero("t1");

    // 2: single write then read
    idle_inputs(); s_write = 2'b01; s_wa1 = 5; s_wr1 = 32'hDEADBEEF; tick();
    idle_inputs(); s_re = 1'b1; s_ra1 = 5; tick();
    check("t2_rd1", if0.rd1, 32'hDEADBEEF);
    check("t2_rdv", DW'(if0.rd_valid), DW'(1));

    // 3: same-address collision, port 2 wins
    idle_inputs(); s_write = 2'b11; s_wa1 = 7; s_wa2 = 7; s_wr1 = 32'h11; s_wr2 = 32'h22; tick();
    idle_inputs(); s_re = 1'b1; s_ra2 = 7; tick();
    check("t3_rd2", if0.rd2, 32'h22);

    // 4: write-first bypass on both read ports
    idle_inputs(); s_write = 2'b01; s_wa1 = 9; s_wr1 = 32'h1234;
    s_re = 1'b1; s_ra1 = 9; s_ra2 = 9; tick();
    check("t4_rd1", if0.rd1, 32'h1234);
    check("t4_rd2", if0.rd2, 32'h1234);

    // 5: entry 0 hardwired on dut1 only
    idle_inputs(); s_write = 2'b11; s_wa1 = 0; s_wr1 = 32'hFFFF; s_wa2 = 3; s_wr2 = 32'hAB; tick();
    idle_inputs(); s_re = 1'b1; s_ra1 = 0; s_ra2 = 3; tick();
    check("t5_r0_rd1", if1.rd1, '0);
    check("t5_r0_rd2", if1.rd2, 32'hAB);
    check("t5_norm_rd1", if0.rd1, 32'hFFFF);
    // bypass of a dropped write to entry 0
    idle_inputs(); s_write = 2'b10; s_wa2 = 0; s_wr2 = 32'h55; s_re = 1'b1; tick();
    check("t5_byp_r0", if1.rd1, '0);
    check("t5_byp_norm", if0.rd1, 32'h55);
    // re=0 holds data and drops valid
    idle_inputs(); tick();
    check("hold_rd1", if0.rd1, 32'h55);
    check("hold_rdv", DW'(if0.rd_valid), '0);

    // randomized traffic, addresses biased low to force collisions
    for (int i = 0; i < 400; i++) begin
      idle_inputs();
      s_write = 2'($urandom_range(0, 3));
      s_wr1 = DW'($urandom); s_wr2 = DW'($urandom);
      s_wa1 = AW'((i % 4 == 0) ? $urandom_range(0, DP - 1) : $urandom_range(0, 7));
      s_wa2 = AW'((i % 5 == 0) ? $urandom_range(0, DP - 1) : $urandom_range(0, 7));
      s_re  = 1'($urandom_range(0, 3) != 0);
      s_ra1 = AW'($urandom_range(0, 7));
      s_ra2 = AW'((i % 3 == 0) ? $urandom_range(0, DP - 1) : $urandom_range(0, 7));
      tick();
    end

    // 6: reset in RUN, again mid-sweep, writes ignored during INIT
    for (int a = 1; a <= 4; a++) begin
      idle_inputs(); s_write = 2'b01; s_wa1 = AW'(a); s_wr1 = DW'($urandom) | 1; tick();
    end
    idle_inputs(); s_rst = 1'b1; tick();
    for (int i = 0; i < 10; i++) begin
      idle_inputs(); s_write = 2'b01; s_wa1 = AW'(i + 1); s_wr1 = 32'hA5A5A5A5; s_re = 1'b1; tick();
      check("t6_rdv_init", DW'(if0.rd_valid), '0);
    end
    idle_inputs(); s_rst = 1'b1; tick();
    wait_ready("t6_ready");
    read_all_zero("t6");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
